// File: rtl/vram_loader.sv
// Copies a DEPTH-word synchronous ROM into VRAM, one word per write_clk cycle.
// Optional XOR checksum of each completed frame: define VRAM_LOADER_CHECKSUM_EN.
module vram_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic              vram_ce,
  output logic [ADDR_W-1:0] vram_ad,
  output logic [DATA_W-1:0] vram_data,
  output logic [7:0]        frame_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_AD = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_ad_q, rd_ad_d;
  logic                vram_ce_q, vram_ce_d;
  logic [ADDR_W-1:0]   vram_ad_q, vram_ad_d;
  logic [DATA_W-1:0]   vram_data_q, vram_data_d;
  logic [7:0]          frame_count_q, frame_count_d;

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_vld_q      <= 1'b0;
      rd_ad_q       <= '0;
      vram_ce_q     <= 1'b0;
      vram_ad_q     <= '0;
      vram_data_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_vld_q      <= rd_vld_d;
      rd_ad_q       <= rd_ad_d;
      vram_ce_q     <= vram_ce_d;
      vram_ad_q     <= vram_ad_d;
      vram_data_q   <= vram_data_d;
      frame_count_q <= frame_count_d;
    end
  end

  // rd_vld/rd_ad mark the cycle in which rom_data answers a read; the write
  // stage registers that word, so a word lands in VRAM two edges after its rom_ad.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_vld_d      = 1'b0;
    rd_ad_d       = cnt_q;
    vram_ce_d     = rd_vld_q;
    vram_ad_d     = rd_vld_q ? rd_ad_q : vram_ad_q;
    vram_data_d   = rd_vld_q ? rom_data : vram_data_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        rd_vld_d = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_AD) state_d = DRAIN;
      end
      DRAIN: begin
        if (vram_ce_q && vram_ad_q == LAST_AD) begin
          state_d       = DONE;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
      DONE: begin
        if (start || continuous) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == LOAD) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign rom_ad      = cnt_q;
  assign vram_ce     = vram_ce_q;
  assign vram_ad     = vram_ad_q;
  assign vram_data   = vram_data_q;
  assign frame_count = frame_count_q;

`ifdef VRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  // The final word is still in the write stage on the DRAIN->DONE edge, so fold it in directly.
  always_comb begin
    acc_d      = acc_q;
    checksum_d = checksum_q;
    if (vram_ce_q) acc_d = acc_q ^ vram_data_q;
    if (state_q != LOAD && state_d == LOAD) acc_d = '0;
    if (state_q == DRAIN && state_d == DONE) checksum_d = acc_q ^ vram_data_q;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_vram_loader.sv
// Scoreboard bench for vram_loader (ADDR_W=4): the stimulus side queues expected
// writes and frame-end records, a negedge monitor pops and compares them.
module tb_vram_loader;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          busy, done, vram_ce;
  logic [AW-1:0] rom_ad, vram_ad;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] vram_data, checksum;
  logic [7:0]    frame_count;

  vram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .write_clk  (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .busy       (busy),
    .done       (done),
    .rom_ad     (rom_ad),
    .rom_data   (rom_data),
    .vram_ce    (vram_ce),
    .vram_ad    (vram_ad),
    .vram_data  (vram_data),
    .frame_count(frame_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tbl [DEPTH];
  always @(posedge clk) rom_data <= tbl[rom_ad];

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [AW+DW-1:0] wr_q [$];
  logic [8+DW-1:0]  dn_q [$];
  int unsigned      exp_fc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_tbl(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        0:       tbl[i] = DW'(i * 32'h0101);
        1:       tbl[i] = DW'(i + 1);
        default: tbl[i] = DW'($urandom);
      endcase
    end
  endtask

  // Reference: a frame writes every ROM word once in address order; checksum is their XOR.
  task automatic push_frame();
    logic [DW-1:0] cks;
    cks = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_q.push_back({AW'(i), tbl[i]});
      cks ^= tbl[i];
    end
    exp_fc = (exp_fc + 1) % 256;
`ifndef VRAM_LOADER_CHECKSUM_EN
    cks = '0;
`endif
    dn_q.push_back({8'(exp_fc), cks});
  endtask

  logic done_p = 1'b0;
  always @(negedge clk) begin
    logic [AW+DW-1:0] w;
    logic [8+DW-1:0]  d;
    if (!rst) begin
      done_p <= 1'b0;
    end else begin
      if (vram_ce) begin
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("vram_ad", 32'(vram_ad), 32'(w[AW+DW-1:DW]));
          chk("vram_data", 32'(vram_data), 32'(w[DW-1:0]));
        end
      end
      if (done && !done_p) begin
        chk("done_expected", 32'(dn_q.size() != 0), 32'd1);
        if (dn_q.size() != 0) begin
          d = dn_q.pop_front();
          chk("frame_count", 32'(frame_count), 32'(d[8+DW-1:DW]));
          chk("checksum", 32'(checksum), 32'(d[DW-1:0]));
        end
      end
      done_p <= done;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_vram_ce", 32'(vram_ce), 0);
    chk("rst_rom_ad", 32'(rom_ad), 0);
    chk("rst_vram_ad", 32'(vram_ad), 0);
    chk("rst_vram_data", 32'(vram_data), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_checksum", 32'(checksum), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    wr_q.delete();
    dn_q.delete();
    exp_fc = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Issues one start, optionally with ignored starts at cycles 3 and 9, and waits for nframes dones.
  task automatic run(input int nframes, input bit cont, input bit extra);
    int   seen, n, budget;
    logic prev;
    for (int f = 0; f < nframes; f++) push_frame();
    @(posedge clk); #2;
    continuous = cont;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    seen = 0; n = 0; prev = 1'b0;
    budget = nframes * (DEPTH + 3) + 10;
    while (seen < nframes && n < budget) begin
      @(posedge clk); #2;
      n++;
      start = extra && (n == 3 || n == 9);
      if (cont) chk("done_one_cycle", 32'(prev & done), 0);
      if (done && !prev) begin
        seen++;
        if (seen == 1) chk("start_to_done_latency", 32'(n), 32'(DEPTH + 2));
        if (seen == nframes) continuous = 1'b0;
      end
      prev = done;
    end
    start = 1'b0;
    continuous = 1'b0;
    chk("frames_completed", 32'(seen), 32'(nframes));
    repeat (DEPTH + 4) @(posedge clk);
    #2;
    chk("done_held", 32'(done), 1);
    chk("idle_after_done", 32'(busy), 0);
    chk("writes_outstanding", 32'(wr_q.size()), 0);
    chk("dones_outstanding", 32'(dn_q.size()), 0);
  endtask

  initial begin
    int found;
    set_tbl(0);
    #1;
    chk_reset_outputs();
    #20 rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("idle_without_start", 32'(busy), 0);

    run(1, 1'b0, 1'b0);
    chk("frame_count_after_one", 32'(frame_count), 1);
    set_tbl(1);
    run(1, 1'b0, 1'b0);
    set_tbl(2);
    run(1, 1'b0, 1'b1);
    run(3, 1'b1, 1'b0);

    set_tbl(2);
    push_frame();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); #2;
      if (vram_ce && vram_ad == AW'(7)) found = 1;
    end
    chk("reached_write_7", 32'(found), 1);
    rst = 1'b0;
    #1;
    chk("abort_vram_ce", 32'(vram_ce), 0);
    chk("abort_busy", 32'(busy), 0);
    wr_q.delete();
    dn_q.delete();
    exp_fc = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("post_abort_busy", 32'(busy), 0);
    chk("post_abort_done", 32'(done), 0);
    chk("post_abort_rom_ad", 32'(rom_ad), 0);
    run(1, 1'b0, 1'b0);

    set_tbl(0);
    do_reset();
    run(256, 1'b1, 1'b0);
    chk("frame_count_wrapped", 32'(frame_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
